// File: rtl/led_run_ctrl.sv
// Running-light sequencer: one-hot LED pattern stepped by upstream strobe edges.
// Optional ping-pong mode via `LED_RUN_BOUNCE_EN; default build wraps around.
module led_run_ctrl #(
  parameter int LED_NUM = 4,
  parameter int DWELL   = 1
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Step_In,
  input  logic               Run_En,
  input  logic               Dir,
  output logic [LED_NUM-1:0] LED_Out,
  output logic               Step_Ack,
  output logic               Busy
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);
  localparam logic [LED_NUM-1:0] POS_LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] POS_MSB =
    {1'b1, {(LED_NUM-1){1'b0}}};

  state_t             state_q, state_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic [LED_NUM-1:0] pos_up, pos_dn, pos_nxt;
  logic [7:0]         cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               ack_q, ack_d;
  logic               step_d;
  logic               rise;

  assign rise    = Step_In & ~step_d;
  assign pos_up  = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
  assign pos_dn  = {led_q[0], led_q[LED_NUM-1:1]};
  assign pos_nxt = dir_q ? pos_dn : pos_up;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      led_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ack_q   <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ack_q   <= ack_d;
      step_d  <= Step_In;
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        led_d = '0;
        cnt_d = '0;
        if (Run_En) begin
          state_d = RUN;
          dir_d   = Dir;
          led_d   = Dir ? POS_MSB : POS_LSB;
        end
      end
      RUN: begin
        if (!Run_En) begin
          state_d = IDLE;
          led_d   = '0;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end else if (rise) begin
`ifndef LED_RUN_BOUNCE_EN
          dir_d = Dir;
`endif
          if (cnt_q == LAST) begin
            led_d = pos_nxt;
            cnt_d = '0;
            ack_d = 1'b1;
`ifdef LED_RUN_BOUNCE_EN
            // turn around on arrival so the end bit is lit exactly one dwell
            if (!dir_q && pos_nxt[LED_NUM-1])
              dir_d = 1'b1;
            else if (dir_q && pos_nxt[0])
              dir_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign LED_Out  = led_q;
  assign Step_Ack = ack_q;
  assign Busy     = (state_q == RUN);

endmodule

// File: tb/tb_led_run_ctrl.sv
// Directed bench for led_run_ctrl: DWELL=1 and DWELL=3 instances share stimulus.
// Expected patterns follow `LED_RUN_BOUNCE_EN when that macro is defined.
module tb_led_run_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Step_In;
  logic       Run_En;
  logic       Dir;
  logic [3:0] led1, led3;
  logic       ack1, ack3;
  logic       busy1, busy3;

  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

  led_run_ctrl #(.LED_NUM(4), .DWELL(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .Step_In(Step_In),
    .Run_En(Run_En), .Dir(Dir),
    .LED_Out(led1), .Step_Ack(ack1), .Busy(busy1)
  );

  led_run_ctrl #(.LED_NUM(4), .DWELL(3)) dut3 (
    .CLK(CLK), .RSTn(RSTn), .Step_In(Step_In),
    .Run_En(Run_En), .Dir(Dir),
    .LED_Out(led3), .Step_Ack(ack3), .Busy(busy3)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one strobe held `hold` cycles, then one low cycle
  task automatic strobe(input string tag,
                        input logic [3:0] e1, input logic a1,
                        input logic [3:0] e3, input logic a3,
                        input int hold);
    Step_In = 1'b1;
    tick();
    chk({tag, " led1"}, 16'(led1), 16'(e1));
    chk({tag, " ack1"}, 16'(ack1), 16'(a1));
    chk({tag, " led3"}, 16'(led3), 16'(e3));
    chk({tag, " ack3"}, 16'(ack3), 16'(a3));
    for (int i = 1; i < hold; i++) begin
      tick();
      chk({tag, " held ack1"}, 16'(ack1), 16'd0);
      chk({tag, " held ack3"}, 16'(ack3), 16'd0);
    end
    Step_In = 1'b0;
    tick();
  endtask

  logic [3:0] fwd [5];
  logic [3:0] dw3 [6];
  logic [3:0] dw1 [6];
  logic       da3 [6];
  logic [3:0] pp  [7];

  initial begin
    fwd = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    dw3 = '{4'b1000, 4'b1000, 4'b0100,
            4'b0100, 4'b0100, 4'b0010};
    da3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dw1 = '{4'b0100, 4'b0010, 4'b0001,
            4'b1000, 4'b0100, 4'b0010};
`ifdef LED_RUN_BOUNCE_EN
    pp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
            4'b0010, 4'b0001, 4'b0010};
`else
    pp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
            4'b0010, 4'b0100, 4'b1000};
`endif

    // reset held while run is requested and the strobe toggles
    RSTn = 1'b0; Run_En = 1'b1; Dir = 1'b0; Step_In = 1'b1;
    tick();
    chk("rst led", 16'(led1), 16'd0);
    chk("rst ack", 16'(ack1), 16'd0);
    chk("rst busy", 16'(busy1), 16'd0);
    Step_In = 1'b0;
    tick();
    chk("rst2 led", 16'(led1), 16'd0);
    chk("rst2 busy", 16'(busy3), 16'd0);
    RSTn = 1'b1;
    tick();
    chk("start led1", 16'(led1), 16'b0001);
    chk("start busy1", 16'(busy1), 16'd1);
    chk("start led3", 16'(led3), 16'b0001);

    // forward wrap, 5-cycle strobes; dut3 pattern noted alongside
    for (int i = 0; i < 5; i++)
      strobe("fwd", fwd[i], 1'b1,
             (i >= 2) ? 4'b0010 : 4'b0001, (i == 2), 5);

    // stop, then restart downward for the dwell test
    Run_En = 1'b0;
    tick();
    chk("stop led1", 16'(led1), 16'd0);
    chk("stop busy3", 16'(busy3), 16'd0);
    Dir = 1'b1; Run_En = 1'b1;
    tick();
    chk("dn start led1", 16'(led1), 16'b1000);
    chk("dn start led3", 16'(led3), 16'b1000);
    for (int i = 0; i < 6; i++)
      strobe("dwell", dw1[i], 1'b1, dw3[i], da3[i], 2);

    // leave dut3 counter at 1 before the collision
    strobe("pre", 4'b0001, 1'b1, 4'b0010, 1'b0, 1);

    // stop and rise in the same cycle: stop wins
    Step_In = 1'b1; Run_En = 1'b0;
    tick();
    chk("coll led1", 16'(led1), 16'd0);
    chk("coll ack1", 16'(ack1), 16'd0);
    chk("coll led3", 16'(led3), 16'd0);
    chk("coll ack3", 16'(ack3), 16'd0);
    Step_In = 1'b0;
    tick();
    Dir = 1'b0; Run_En = 1'b1;
    tick();
    chk("restart led3", 16'(led3), 16'b0001);
    strobe("rs1", 4'b0010, 1'b1, 4'b0001, 1'b0, 1);
    strobe("rs2", 4'b0100, 1'b1, 4'b0001, 1'b0, 1);
    strobe("rs3", 4'b1000, 1'b1, 4'b0010, 1'b1, 1);

    // strobe already high when run starts
    Run_En = 1'b0;
    tick();
    Step_In = 1'b1;
    tick();
    Run_En = 1'b1;
    tick();
    chk("held start", 16'(led1), 16'b0001);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held led", 16'(led1), 16'b0001);
      chk("held ack", 16'(ack1), 16'd0);
    end
    Step_In = 1'b0;
    tick();
    Step_In = 1'b1;
    tick();
    chk("held adv led", 16'(led1), 16'b0010);
    chk("held adv ack", 16'(ack1), 16'd1);
    Step_In = 1'b0;
    tick();
    chk("held ack drop", 16'(ack1), 16'd0);

    // seven-step run through both ends
    Run_En = 1'b0;
    tick();
    Run_En = 1'b1;
    tick();
    chk("pp start", 16'(led1), 16'b0001);
    for (int i = 0; i < 7; i++)
      strobe("pp", pp[i], 1'b1,
             (i >= 2 && i < 5) ? 4'b0010 : ((i >= 5) ? 4'b0100 : 4'b0001),
             (i == 2 || i == 5), 1);

    // reset mid-run blanks at the same edge
    RSTn = 1'b0;
    tick();
    chk("midrst led1", 16'(led1), 16'd0);
    chk("midrst busy1", 16'(busy1), 16'd0);
    chk("midrst led3", 16'(led3), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
